// File: rtl/i2s_xmit.sv
// i2s_xmit: Philips I2S transmitter/bus master generating bck and lrck from mck,
// with a one-frame holding buffer filled through a valid/ready handshake.
module i2s_xmit #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int BCK_HALF = 2
) (
    input  logic              mck,
    input  logic              reset,
    input  logic [DATA_W-1:0] left_in,
    input  logic [DATA_W-1:0] right_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bck,
    output logic              lrck,
    output logic              sd,
    output logic              frame_start,
    output logic              underrun
);
    localparam int BW = $clog2(2 * SLOT_W);
    localparam int DW = BCK_HALF > 1 ? $clog2(BCK_HALF) : 1;
    localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST = BW'(2 * SLOT_W - 1);
    localparam logic [BW-1:0] SLOT = BW'(SLOT_W);
    localparam logic [BW-1:0] DATA = BW'(DATA_W);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_HALF - 1);

    logic [DW-1:0]     div_cnt;
    logic [BW-1:0]     bit_cnt, bit_nxt, pos;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] buf_l, buf_r, sh_l, sh_r, word;
    logic              buf_full, fall, load, accept, right_nxt, sd_nxt;

    always_comb begin
        fall      = bck && div_cnt == DIV_LAST;
        bit_nxt   = bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
        load      = fall && bit_nxt == '0;
        accept    = in_valid && !buf_full;
        right_nxt = bit_nxt >= SLOT;
        pos       = right_nxt ? bit_nxt - SLOT : bit_nxt;
        idx       = IW'(DATA - pos);
        word      = right_nxt ? sh_r : sh_l;
        // slot position 0 is the one-bck delay bit; positions past DATA_W are padding
        sd_nxt    = (pos != '0 && pos <= DATA) ? word[idx] : 1'b0;
    end

    assign in_ready = !buf_full;

    always_ff @(posedge mck) begin
        if (!reset) begin
            div_cnt     <= '0;
            bck         <= 1'b0;
            bit_cnt     <= LAST;
            lrck        <= 1'b1;
            sd          <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            buf_full    <= 1'b0;
            buf_l       <= '0;
            buf_r       <= '0;
            sh_l        <= '0;
            sh_r        <= '0;
        end else begin
            div_cnt     <= div_cnt == DIV_LAST ? '0 : div_cnt + 1'b1;
            bck         <= div_cnt == DIV_LAST ? !bck : bck;
            frame_start <= load;
            underrun    <= load && !buf_full;
            if (fall) begin
                bit_cnt <= bit_nxt;
                lrck    <= right_nxt;
                sd      <= sd_nxt;
            end
            // an empty buffer at load time sends silence; a same-edge accept waits a frame
            if (load) begin
                sh_l <= buf_full ? buf_l : '0;
                sh_r <= buf_full ? buf_r : '0;
            end
            if (accept) begin
                buf_l <= left_in;
                buf_r <= right_in;
            end
            buf_full <= accept || (buf_full && !load);
        end
    end
endmodule

// File: tb/tb_i2s_xmit.sv
// tb_i2s_xmit: directed checks of i2s_xmit at default parameters and at
// BCK_HALF=1, SLOT_W=25, capturing sd/lrck on bck rising edges.
module tb_i2s_xmit;
    logic        mck = 1'b0;
    logic        reset;
    logic [23:0] left_in, right_in, l2, r2;
    logic        in_valid, in_valid2;
    logic        in_ready, bck, lrck, sd, fs, ur;
    logic        rdy2, bck2, lrck2, sd2, fs2, ur2;
    logic        sel = 1'b0;
    int          n_chk = 0, n_err = 0;
    int          cnt1 = 0, cnt2 = 0, per1 = 0, per2 = 0;
    logic [63:0] sdv, lrv;
    logic        urf, rdy_all;

    always #5 mck = !mck;

    i2s_xmit dut (
        .mck(mck), .reset(reset), .left_in(left_in), .right_in(right_in),
        .in_valid(in_valid), .in_ready(in_ready), .bck(bck), .lrck(lrck),
        .sd(sd), .frame_start(fs), .underrun(ur)
    );

    i2s_xmit #(.DATA_W(24), .SLOT_W(25), .BCK_HALF(1)) dut2 (
        .mck(mck), .reset(reset), .left_in(l2), .right_in(r2),
        .in_valid(in_valid2), .in_ready(rdy2), .bck(bck2), .lrck(lrck2),
        .sd(sd2), .frame_start(fs2), .underrun(ur2)
    );

    wire c_bck = sel ? bck2 : bck;
    wire c_lr  = sel ? lrck2 : lrck;
    wire c_sd  = sel ? sd2 : sd;
    wire c_fs  = sel ? fs2 : fs;
    wire c_ur  = sel ? ur2 : ur;
    wire c_rdy = sel ? rdy2 : in_ready;

    always @(negedge mck) begin
        if (fs) begin per1 <= cnt1; cnt1 <= 1; end else cnt1 <= cnt1 + 1;
        if (fs2) begin per2 <= cnt2; cnt2 <= 1; end else cnt2 <= cnt2 + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] frame64(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    task automatic wait_fs();
        int n = 0;
        @(negedge mck);
        while (!c_fs && n < 400) begin @(negedge mck); n++; end
        check("fs_seen", 64'(c_fs), 64'd1);
    endtask

    task automatic cap(input logic wfs, input int nbits, output logic [63:0] s,
                       output logic [63:0] l, output logic u, output logic r);
        int n = 0, bits = 0;
        logic pb;
        s = '0; l = '0; r = 1'b1;
        if (wfs) wait_fs();
        u = c_ur;
        pb = c_bck;
        while (bits < nbits && n < 600) begin
            @(negedge mck);
            n++;
            r &= c_rdy;
            if (c_bck && !pb) begin
                s = {s[62:0], c_sd};
                l = {l[62:0], c_lr};
                bits++;
            end
            pb = c_bck;
        end
        check("cap_bits", 64'(bits), 64'(nbits));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        left_in = '0; right_in = '0; l2 = '0; r2 = '0;
        repeat (3) @(negedge mck);
        check("reset_state", 64'({bck, lrck, sd, fs, ur, in_ready}), 64'b010001);
        // first frame: pair accepted at edge 1, loaded at edge 4
        left_in = 24'h888888; right_in = 24'hF0F0F0; in_valid = 1'b1;
        reset = 1'b1;
        @(negedge mck);
        check("e1_bck_rdy", 64'({bck, in_ready}), 64'b00);
        in_valid = 1'b0;
        @(negedge mck);
        check("e2_bck", 64'(bck), 64'd1);
        @(negedge mck);
        check("e3_bck_fs", 64'({bck, fs}), 64'b10);
        @(negedge mck);
        check("e4_load", 64'({fs, ur, bck, lrck, in_ready}), 64'b10001);
        cap(1'b0, 64, sdv, lrv, urf, rdy_all);
        check("f1_sd", sdv, frame64(24'h888888, 24'hF0F0F0));
        check("f1_lrck", lrv, {32'h0, 32'hFFFFFFFF});
        // idle source: silent underrun frame
        cap(1'b1, 64, sdv, lrv, urf, rdy_all);
        check("ur_flag", 64'(urf), 64'd1);
        check("ur_sd", sdv, 64'd0);
        check("ur_rdy", 64'(rdy_all), 64'd1);
        check("period256", 64'(per1), 64'd256);
        // back-to-back pairs
        wait_fs();
        repeat (10) @(negedge mck);
        left_in = 24'h7FFFFF; right_in = 24'h800000; in_valid = 1'b1;
        @(negedge mck);
        check("rdy_drop", 64'(in_ready), 64'd0);
        left_in = 24'h000001; right_in = 24'hFFFFFF;
        fork
            cap(1'b1, 64, sdv, lrv, urf, rdy_all);
            begin
                int n = 0;
                @(negedge mck);
                while (!in_ready && n < 400) begin @(negedge mck); n++; end
                check("rdy_rise_at_load", 64'({in_ready, fs}), 64'b11);
                @(negedge mck);
                in_valid = 1'b0;
                check("rdy_drop2", 64'(in_ready), 64'd0);
            end
        join
        check("b1_sd", sdv, frame64(24'h7FFFFF, 24'h800000));
        check("b1_ur", 64'(urf), 64'd0);
        cap(1'b1, 64, sdv, lrv, urf, rdy_all);
        check("b2_sd", sdv, frame64(24'h000001, 24'hFFFFFF));
        check("b2_ur", 64'(urf), 64'd0);
        // accept on the load edge with the buffer empty
        wait_fs();
        repeat (255) @(negedge mck);
        left_in = 24'hA5A5A5; right_in = 24'h123456; in_valid = 1'b1;
        @(negedge mck);
        check("same_edge", 64'({fs, ur, in_ready}), 64'b110);
        in_valid = 1'b0;
        cap(1'b0, 64, sdv, lrv, urf, rdy_all);
        check("same_edge_silent", sdv, 64'd0);
        cap(1'b1, 64, sdv, lrv, urf, rdy_all);
        check("held_pair_sd", sdv, frame64(24'hA5A5A5, 24'h123456));
        check("held_pair_ur", 64'(urf), 64'd0);
        // reset mid right slot with a pair buffered
        wait_fs();
        repeat (5) @(negedge mck);
        left_in = 24'h111111; right_in = 24'h222222; in_valid = 1'b1;
        @(negedge mck);
        in_valid = 1'b0;
        check("buf_full", 64'(in_ready), 64'd0);
        repeat (150) @(negedge mck);
        check("in_right_slot", 64'(lrck), 64'd1);
        reset = 1'b0;
        @(negedge mck);
        check("mid_reset", 64'({bck, lrck, sd, in_ready, fs, ur}), 64'b010100);
        reset = 1'b1;
        cap(1'b1, 64, sdv, lrv, urf, rdy_all);
        check("post_reset_ur", 64'(urf), 64'd1);
        check("post_reset_sd", sdv, 64'd0);
        // BCK_HALF=1, SLOT_W=25: no padding, LSB in slot bit 24
        sel = 1'b1;
        wait_fs();
        repeat (5) @(negedge mck);
        l2 = 24'h800001; r2 = 24'h400003; in_valid2 = 1'b1;
        @(negedge mck);
        in_valid2 = 1'b0;
        check("d2_rdy_drop", 64'(rdy2), 64'd0);
        cap(1'b1, 50, sdv, lrv, urf, rdy_all);
        check("d2_sd", sdv, {14'b0, 1'b0, 24'h800001, 1'b0, 24'h400003});
        check("d2_lrck", lrv, {39'b0, 25'h1FFFFFF});
        check("d2_ur", 64'(urf), 64'd0);
        check("period100", 64'(per2), 64'd100);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/i2s_xmit.md
Name: i2s_xmit

Overview:
- I2S transmitter and bus master: the transmit-side counterpart of the existing I2S receive path.
- Runs entirely on mck. Internally divides mck to generate bck and lrck.
- Accepts stereo 24-bit sample pairs through a valid/ready handshake into a one-frame holding buffer.
- Serialises each pair MSB-first in Philips I2S format: data changes on bck falling edge, MSB delayed one bck after each lrck edge.

Parameters:
- DATA_W, 24, sample width in bits.
- SLOT_W, 32, bck periods per channel slot. Must satisfy SLOT_W >= DATA_W+1.
- BCK_HALF, 2, mck cycles per bck half-period. Must be >= 1. One bck period = 2*BCK_HALF mck cycles.

Ports:
- mck  input  1  master clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- left_in  input  DATA_W  left sample, two's complement.
- right_in  input  DATA_W  right sample.
- in_valid  input  1  the pair on left_in/right_in is valid.
- in_ready  output  1  the holding buffer is empty and can accept a pair.
- bck  output  1  bit clock, registered.
- lrck  output  1  word select, registered: 0 = left, 1 = right.
- sd  output  1  serial data, registered.
- frame_start  output  1  one-mck pulse on each frame load event.
- underrun  output  1  one-mck pulse when a frame loads with the buffer empty.

Behaviour:
- Reset values (reset=0 at an mck edge):
  - bck=0, lrck=1, sd=0, frame_start=0, underrun=0, in_ready=1.
  - Divider counter div_cnt=0, bit counter bit_cnt=2*SLOT_W-1.
  - Holding buffer empty. Shift words cleared.
- Divider:
  - div_cnt counts 0..BCK_HALF-1.
  - When div_cnt==BCK_HALF-1: bck toggles and div_cnt goes to 0. Otherwise div_cnt increments.
  - A fall event is a toggle while bck==1.
  - With BCK_HALF=2, counting mck edges after reset goes high: bck rises at edge 2 and first falls at edge 4.
- bit_cnt (0..2*SLOT_W-1) advances only on fall events, wrapping from 2*SLOT_W-1 to 0. All output updates below happen on fall events only.
- lrck takes the value (new bit_cnt >= SLOT_W), registered on the fall event.
- Slot position p = new bit_cnt mod SLOT_W.
  - For 1 <= p <= DATA_W: sd = word[DATA_W-p], where word is the left shift word when lrck=0 and the right shift word when lrck=1.
  - Otherwise sd = 0. This covers p=0 (the delay bit) and the padding bits.
  - Result: the MSB appears on the bck after the lrck edge, and the receiver samples on bck rising.
- Frame load (fall event with bit_cnt wrapping to 0):
  - Buffer full: copy the buffer to the shift words, mark the buffer empty, pulse frame_start.
  - Buffer empty: shift words become 0 (silence); pulse both frame_start and underrun.
- Handshake:
  - A pair is accepted on the mck edge where in_valid && in_ready. The buffer becomes full and in_ready=0 from the next cycle.
  - in_ready returns to 1 on the cycle after the load that empties the buffer.
  - No bypass. If an accept and a load fall on the same edge while the buffer is empty, the load underruns and the accepted pair is held for the next frame.
- Frame length: 2*SLOT_W*2*BCK_HALF mck cycles, which is 256 at the defaults.
- Reset mid-frame: every register returns to its reset value at that edge and the buffered pair is discarded. The first frame after reset begins at the first fall event.
- in_valid with in_ready=0 is ignored. The source must hold the pair until it is accepted.

Test Plan:
- Defaults; release reset, then present left=888888, right=F0F0F0 with in_valid before edge 4 -> frame_start at edge 4; lrck low for 32 bck then high for 32; sd sampled on bck rising gives 0, 888888 MSB-first, 7 zeros in the left slot, and 0, F0F0F0, 7 zeros in the right slot.
- in_valid held low -> underrun and frame_start pulse every 256 mck; sd constant 0; in_ready stays 1.
- Back-to-back pairs 7FFFFF/800000 then 000001/FFFFFF -> in_ready drops the cycle after the first accept and rises the cycle after the load; each pair appears in consecutive frames; sign bits are correct.
- in_valid asserted exactly on the load edge with the buffer empty -> underrun=1 and that frame is silent; the pair is transmitted in the following frame.
- reset=0 for one cycle mid right slot with a pair buffered -> next edge bck=0, lrck=1, sd=0, in_ready=1; the buffered pair is never transmitted.
- BCK_HALF=1, SLOT_W=25 -> bck period 2 mck, frame 100 mck, no padding bits; sd bit 24 of each slot is the LSB.
